memoria_escritura: RTL and testbench
====================================

// Module: memoria_escritura
// PURPOSE
// Write-side sequencer for the RTC multiplexed address/data bus; pairs with the read sequencer that loads time/timer from the RTC.
// On start, latches user-set time and/or timer values and writes them to RTC registers 0x21-0x26 / 0x41-0x43.
// Then issues the 0xF1 transfer command (RAM -> RTC counters). Self-timed FSM with busy/done handshake.
// Sits between the user-edit logic and the shared RTC bus mux.
// PARAMETERS
// PHASE_CYCLES  4  clocks each bus phase is held (>=1); sets strobe width for RTC timing
// PORTS
// clk       in   1  system clock, rising edge
// rst       in   1  asynchronous reset, active-low (0 = reset)
// start     in   1  request; sampled only in IDLE
// mode      in   2  01 = clock regs, 10 = timer regs, 11 = both, 00 = no-op
// s,m,h     in   8  BCD seconds/minutes/hours -> 0x21/0x22/0x23
// d,me,a    in   8  BCD day/month/year -> 0x24/0x25/0x26
// st,mt,ht  in   8  BCD timer sec/min/hour -> 0x41/0x42/0x43
// AD,CS,RD,WR  out 1  RTC strobes, active-low; AD=0 address, AD=1 data
// Dir_Dat   out  1  bus direction; held 0 (FPGA drives) in this block
// Dato_out  out  8  multiplexed address/data driven onto the RTC bus
// busy      out  1  high while a sequence is in progress
// done      out  1  one-clock pulse when the sequence completes
// BEHAVIOUR
// - Reset (async, rst=0): AD=CS=RD=WR=1, Dir_Dat=0, Dato_out=0, busy=0, done=0, FSM=IDLE, latched data cleared.
// - Reset asserted mid-sequence aborts immediately; outputs return to reset values in the same cycle, with no partial strobe held.
// - IDLE: outputs idle as in reset. On start=1 with mode!=00: latch mode and all 9 data inputs, build transaction list, go to A_SET.
//   start with mode=00 -> stays IDLE, busy stays 0. start while busy -> ignored.
// - Transaction list order: clock regs 0x21..0x26 (if mode[0]), then timer regs 0x41..0x43 (if mode[1]), then cmd 0xF1 with data 0x00.
//   N = 7 (mode 01), 4 (mode 10), 10 (mode 11).
// - Per transaction, 5 phases of PHASE_CYCLES clocks each:
//   A_SET : AD=0 CS=1 WR=1, Dato_out=addr
//   A_STB : AD=0 CS=0 WR=0, Dato_out=addr
//   A_HLD : AD=0 CS=1 WR=1, Dato_out=addr
//   D_STB : AD=1 CS=0 WR=0, Dato_out=data
//   D_HLD : AD=1 CS=1 WR=1, Dato_out=data
// - After D_HLD: next transaction's A_SET, or DONE after the last transaction.
// - RD=1 and Dir_Dat=0 in every state. All outputs are registered, so there are no glitches on strobes.
// - busy=1 from the clock after start is accepted through the last D_HLD cycle, i.e. 5*PHASE_CYCLES*N cycles.
// - DONE: one cycle with busy=0 and done=1, then IDLE. A new start is accepted in the cycle after DONE.
// - Phase counter: ceil(log2(PHASE_CYCLES)) bits, resets to 0 at each phase entry. Transaction index is 4 bits, max 9.
// - Data is passed through unmodified (no BCD check). Changes on data inputs while busy have no effect.
// TESTING
// - Reset: rst=0 mid D_STB -> same cycle AD=CS=RD=WR=1, busy=0, Dato_out=0; rst=1 -> IDLE, no strobe until next start.
// - mode=01, P=1, s=0x45 m=0x30 h=0x12 d=0x07 me=0x03 a=0x16:
//   -> WR pulses at addr 0x21..0x26 then 0xF1 with data 45,30,12,07,03,16,00; busy 35 cycles; single done pulse.
// - mode=10, P=4, st=0x10 mt=0x05 ht=0x01:
//   -> writes 0x41=10, 0x42=05, 0x43=01, 0xF1=00; each CS/WR low exactly 4 cycles; busy=80 cycles.
// - mode=11, P=1: 10 transactions in order 21..26, 41..43, F1; busy=50 cycles; RD never 0; Dir_Dat never 1.
// - Protocol check: start pulsed again while busy and with mode=00 in IDLE -> no extra transactions, busy unaffected.
// - Input stability: change s to 0x59 after start accepted -> bus still writes the latched value at 0x21.

Source files
------------

// File: rtl/memoria_escritura.sv
// -----------------------------------------------------------------------------
// memoria_escritura
// Write-side sequencer for the RTC multiplexed address/data bus.
// On an accepted start it latches the user-set time and/or timer values. It
// then writes them to RTC registers 0x21-0x26 (clock) and 0x41-0x43 (timer),
// and finishes with the 0xF1 transfer command, which copies RAM into the RTC
// counters. Each register write has five bus phases, and each phase lasts
// PHASE_CYCLES clocks. All bus outputs are registered, so the strobes do not
// glitch.
//
// Ports
//   clk                    system clock, rising edge
//   rst                    asynchronous reset, active-low
//   start                  sequence request, sampled only in IDLE
//   mode[1:0]              01 clock regs, 10 timer regs, 11 both, 00 no-op
//   s,m,h,d,me,a [7:0]     BCD sec/min/hour/day/month/year -> 0x21..0x26
//   st,mt,ht [7:0]         BCD timer sec/min/hour -> 0x41..0x43
//   AD,CS,RD,WR            RTC strobes, active-low (AD=0 address, AD=1 data)
//   Dir_Dat                bus direction, always 0 (FPGA drives)
//   Dato_out[7:0]          multiplexed address/data onto the RTC bus
//   busy                   high while a sequence is on the bus
//   done                   one-clock completion pulse
// -----------------------------------------------------------------------------
module memoria_escritura #(
  parameter int PHASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] s,
  input  logic [7:0] m,
  input  logic [7:0] h,
  input  logic [7:0] d,
  input  logic [7:0] me,
  input  logic [7:0] a,
  input  logic [7:0] st,
  input  logic [7:0] mt,
  input  logic [7:0] ht,
  output logic       AD,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       Dir_Dat,
  output logic [7:0] Dato_out,
  output logic       busy,
  output logic       done
);

  // A phase counter needs at least one bit, even when PHASE_CYCLES is 1.
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [3:0]    SLOT_CMD = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_SET = 3'd1,
    A_STB = 3'd2,
    A_HLD = 3'd3,
    D_STB = 3'd4,
    D_HLD = 3'd5,
    DONE  = 3'd6
  } state_t;

  // The canonical slot numbers are 0..5 for the clock regs, 6..8 for the
  // timer regs and 9 for the 0xF1 command. The transaction index is mapped
  // onto a slot according to the latched mode. With this mapping the
  // transaction list never has to be stored.
  function automatic logic [3:0] slot_of(input logic [1:0] md, input logic [3:0] idx);
    logic [3:0] sl;
    case (md)
      2'b01:   sl = (idx <= 4'd5) ? idx : SLOT_CMD;
      2'b10:   sl = (idx <= 4'd2) ? (idx + 4'd6) : SLOT_CMD;
      2'b11:   sl = (idx <= 4'd9) ? idx : SLOT_CMD;
      default: sl = SLOT_CMD;
    endcase
    return sl;
  endfunction

  function automatic logic [7:0] addr_of(input logic [3:0] slot);
    logic [7:0] ad;
    case (slot)
      4'd0:    ad = 8'h21;
      4'd1:    ad = 8'h22;
      4'd2:    ad = 8'h23;
      4'd3:    ad = 8'h24;
      4'd4:    ad = 8'h25;
      4'd5:    ad = 8'h26;
      4'd6:    ad = 8'h41;
      4'd7:    ad = 8'h42;
      4'd8:    ad = 8'h43;
      default: ad = 8'hF1;
    endcase
    return ad;
  endfunction

  function automatic logic [7:0] data_of(input logic [3:0] slot, input logic [8:0][7:0] dat);
    logic [7:0] dv;
    case (slot)
      4'd0:    dv = dat[0];
      4'd1:    dv = dat[1];
      4'd2:    dv = dat[2];
      4'd3:    dv = dat[3];
      4'd4:    dv = dat[4];
      4'd5:    dv = dat[5];
      4'd6:    dv = dat[6];
      4'd7:    dv = dat[7];
      4'd8:    dv = dat[8];
      default: dv = 8'h00;
    endcase
    return dv;
  endfunction

  state_t          state_r, state_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic [3:0]      idx_r, idx_n;
  logic [1:0]      mode_r;
  logic [8:0][7:0] dat_r;
  logic            latch_s;
  logic            phase_end_s;
  logic [3:0]      cur_slot_s;
  logic [1:0]      mode_n_s;
  logic [3:0]      nxt_slot_s;
  logic            ad_n, cs_n, wr_n, busy_n, done_n;
  logic [7:0]      dato_n;

  // Next-state logic: start acceptance, phase timing and stepping to the next transaction.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    idx_n       = idx_r;
    latch_s     = 1'b0;
    phase_end_s = (cnt_r == CNT_LAST);
    cur_slot_s  = slot_of(mode_r, idx_r);
    case (state_r)
      IDLE: begin
        if (start && (mode != 2'b00)) begin
          state_n = A_SET;
          cnt_n   = CNT_ZERO;
          idx_n   = 4'd0;
          latch_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      A_SET, A_STB, A_HLD, D_STB: begin
        if (phase_end_s) begin
          cnt_n = CNT_ZERO;
          case (state_r)
            A_SET:   state_n = A_STB;
            A_STB:   state_n = A_HLD;
            A_HLD:   state_n = D_STB;
            default: state_n = D_HLD;
          endcase
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      D_HLD: begin
        if (phase_end_s) begin
          cnt_n = CNT_ZERO;
          if (cur_slot_s == SLOT_CMD) begin
            state_n = DONE;
          end else begin
            idx_n   = idx_r + 4'd1;
            state_n = A_SET;
          end
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output decode from the next state, so that the bus pins can be registered
  // without a cycle of lag. The mode input is used directly on the accept
  // cycle because mode_r is only updated on the following clock edge.
  always_comb begin
    ad_n       = 1'b1;
    cs_n       = 1'b1;
    wr_n       = 1'b1;
    dato_n     = 8'h00;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    mode_n_s   = latch_s ? mode : mode_r;
    nxt_slot_s = slot_of(mode_n_s, idx_n);
    case (state_n)
      A_SET: begin
        ad_n = 1'b0; dato_n = addr_of(nxt_slot_s); busy_n = 1'b1;
      end
      A_STB: begin
        ad_n = 1'b0; cs_n = 1'b0; wr_n = 1'b0; dato_n = addr_of(nxt_slot_s); busy_n = 1'b1;
      end
      A_HLD: begin
        ad_n = 1'b0; dato_n = addr_of(nxt_slot_s); busy_n = 1'b1;
      end
      D_STB: begin
        cs_n = 1'b0; wr_n = 1'b0; dato_n = data_of(nxt_slot_s, dat_r); busy_n = 1'b1;
      end
      D_HLD: begin
        dato_n = data_of(nxt_slot_s, dat_r); busy_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      IDLE:    done_n = 1'b0;
      default: done_n = 1'b0;
    endcase
  end

  // FSM state, phase counter and transaction index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 4'd0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
    end
  end

  // Capture mode and register values when a start is accepted. Later input
  // changes are ignored until the next accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r <= 2'b00;
      dat_r  <= {9{8'h00}};
    end else if (latch_s) begin
      mode_r <= mode;
      dat_r  <= {ht, mt, st, a, me, d, h, m, s};
    end else begin
      mode_r <= mode_r;
      dat_r  <= dat_r;
    end
  end

  // Registered bus pins and handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AD       <= 1'b1;
      CS       <= 1'b1;
      RD       <= 1'b1;
      WR       <= 1'b1;
      Dir_Dat  <= 1'b0;
      Dato_out <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      AD       <= ad_n;
      CS       <= cs_n;
      RD       <= 1'b1;
      WR       <= wr_n;
      Dir_Dat  <= 1'b0;
      Dato_out <= dato_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_memoria_escritura.sv
module tb_memoria_escritura;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4;
  logic [1:0] mode;
  logic [7:0] s, m, h, d, me, a, st, mt, ht;

  logic       ad1, cs1, rd1, wr1, dir1, busy1, done1;
  logic [7:0] dato1;
  logic       ad4, cs4, rd4, wr4, dir4, busy4, done4;
  logic [7:0] dato4;

  logic       sel;
  logic       o_ad, o_cs, o_rd, o_wr, o_dir, o_busy, o_done;
  logic [7:0] o_dato;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memoria_escritura #(.PHASE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mode(mode),
    .s(s), .m(m), .h(h), .d(d), .me(me), .a(a), .st(st), .mt(mt), .ht(ht),
    .AD(ad1), .CS(cs1), .RD(rd1), .WR(wr1), .Dir_Dat(dir1), .Dato_out(dato1),
    .busy(busy1), .done(done1)
  );

  memoria_escritura #(.PHASE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode),
    .s(s), .m(m), .h(h), .d(d), .me(me), .a(a), .st(st), .mt(mt), .ht(ht),
    .AD(ad4), .CS(cs4), .RD(rd4), .WR(wr4), .Dir_Dat(dir4), .Dato_out(dato4),
    .busy(busy4), .done(done4)
  );

  assign o_ad   = sel ? ad4   : ad1;
  assign o_cs   = sel ? cs4   : cs1;
  assign o_rd   = sel ? rd4   : rd1;
  assign o_wr   = sel ? wr4   : wr1;
  assign o_dir  = sel ? dir4  : dir1;
  assign o_busy = sel ? busy4 : busy1;
  assign o_done = sel ? done4 : done1;
  assign o_dato = sel ? dato4 : dato1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) start4 = v; else start1 = v;
  endtask

  // Runs one sequence on the selected DUT and watches the bus every cycle.
  task automatic run_seq(input logic use4, input logic [1:0] md, input int pc,
                         input logic chg_s, input logic restart, input string tag);
    logic [7:0] ea[10], ed[10], got_a[16], got_d[16];
    logic [7:0] clk_v[6], tmr_v[3];
    int n, na, nd, busy_cnt, done_cnt, done_busy, rd_bad, dir_bad, cs_bad, strobe_bad, run, limit;
    logic prev_wr;
    sel = use4;
    clk_v = '{s, m, h, d, me, a};
    tmr_v = '{st, mt, ht};
    n = 0;
    if (md[0]) for (int k = 0; k < 6; k++) begin ea[n] = 8'h21 + 8'(k); ed[n] = clk_v[k]; n++; end
    if (md[1]) for (int k = 0; k < 3; k++) begin ea[n] = 8'h41 + 8'(k); ed[n] = tmr_v[k]; n++; end
    ea[n] = 8'hF1; ed[n] = 8'h00; n++;
    na = 0; nd = 0; busy_cnt = 0; done_cnt = 0; done_busy = 0;
    rd_bad = 0; dir_bad = 0; cs_bad = 0; strobe_bad = 0; run = 0; prev_wr = 1'b1;
    limit = 5 * pc * n + 4;
    @(negedge clk);
    mode = md;
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    for (int cyc = 0; cyc < limit; cyc++) begin
      if (o_busy === 1'b1) busy_cnt++;
      if (o_done === 1'b1) begin done_cnt++; if (o_busy !== 1'b0) done_busy++; end
      if (o_rd !== 1'b1) rd_bad++;
      if (o_dir !== 1'b0) dir_bad++;
      if (o_cs !== o_wr) cs_bad++;
      if (o_wr === 1'b0) begin
        if (prev_wr === 1'b1) begin
          if (o_ad === 1'b0) begin if (na < 16) got_a[na] = o_dato; na++; end
          else begin if (nd < 16) got_d[nd] = o_dato; nd++; end
        end
        run++;
      end else begin
        if (prev_wr === 1'b0 && run != pc) strobe_bad++;
        run = 0;
      end
      prev_wr = o_wr;
      if (chg_s && cyc == 2) s = 8'h59;
      if (restart && cyc == 3) begin mode = 2'b11; drive_start(1'b1); end
      if (restart && cyc == 4) begin mode = md; drive_start(1'b0); end
      @(negedge clk);
    end
    chk({tag, " addr_count"}, na, n);
    chk({tag, " data_count"}, nd, n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s addr[%0d]", tag, k), (k < 16) ? got_a[k] : 8'hxx, ea[k]);
      chk($sformatf("%s data[%0d]", tag, k), (k < 16) ? got_d[k] : 8'hxx, ed[k]);
    end
    chk({tag, " busy_cycles"}, busy_cnt, 5 * pc * n);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_at_done"}, done_busy, 0);
    chk({tag, " rd_low"}, rd_bad, 0);
    chk({tag, " dir_high"}, dir_bad, 0);
    chk({tag, " cs_wr_mismatch"}, cs_bad, 0);
    chk({tag, " strobe_width"}, strobe_bad, 0);
  endtask

  initial begin
    int bad, found;
    rst = 1'b0; start1 = 1'b0; start4 = 1'b0; mode = 2'b00; sel = 1'b0;
    s = 8'h45; m = 8'h30; h = 8'h12; d = 8'h07; me = 8'h03; a = 8'h16;
    st = 8'h10; mt = 8'h05; ht = 8'h01;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    chk("rst1 strobes", {ad1, cs1, rd1, wr1}, 4'hF);
    chk("rst1 dir/busy/done", {dir1, busy1, done1}, 3'b000);
    chk("rst1 dato", dato1, 8'h00);
    chk("rst4 strobes", {ad4, cs4, rd4, wr4}, 4'hF);
    chk("rst4 dato", dato4, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clock regs, P=1, s changed after acceptance, latched value expected
    run_seq(1'b0, 2'b01, 1, 1'b1, 1'b0, "m01p1");
    s = 8'h45;

    // Timer regs, P=4, start re-pulsed while busy
    run_seq(1'b1, 2'b10, 4, 1'b0, 1'b1, "m10p4");

    // Both, P=1
    run_seq(1'b0, 2'b11, 1, 1'b0, 1'b0, "m11p1");

    // mode=00 start in IDLE is a no-op
    sel = 1'b0;
    @(negedge clk);
    mode = 2'b00; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy1 !== 1'b0 || wr1 !== 1'b1 || cs1 !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("mode00 no activity", bad, 0);

    // Reset asserted mid D_STB on the P=4 instance
    sel = 1'b1;
    mode = 2'b01; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (ad4 === 1'b1 && wr4 === 1'b0) found = 1;
      else @(negedge clk);
    end
    chk("reach D_STB", found, 1);
    rst = 1'b0;
    #1;
    chk("midrst strobes", {ad4, cs4, rd4, wr4}, 4'hF);
    chk("midrst busy", busy4, 1'b0);
    chk("midrst dato", dato4, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy4 !== 1'b0 || wr4 !== 1'b1 || cs4 !== 1'b1) bad++;
    end
    chk("post-rst idle", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
